// File: rtl/rsa_link_pkg.sv
// Shared types and default key material for the inter-board ciphertext link.
package rsa_link_pkg;

    localparam int unsigned DATA_W    = 128;
    localparam int unsigned DEF_MOD_W = 16;
    localparam int unsigned DEF_EXP_W = 16;
    localparam int unsigned DEF_N_MOD = 2773;
    localparam int unsigned DEF_D_KEY = 157;

    localparam logic [DATA_W-1:0] ERR_WORD = {DATA_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD,
        S_MUL,
        S_STEP,
        S_SEND
    } state_t;

endpackage

// File: rtl/mod_mul.sv
// Sequential modular multiplier: interleaved shift-add, one b bit per cycle, MSB first.
// The first step is taken on the start edge, so done pulses MOD_W-1 cycles after start.
module mod_mul #(
    parameter int unsigned MOD_W = 16,
    parameter int unsigned N_MOD = 2773
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [MOD_W-1:0] a,
    input  logic [MOD_W-1:0] b,
    output logic [MOD_W-1:0] result,
    output logic             done
);

    localparam int unsigned     CNT_W = $clog2(MOD_W + 1);
    localparam logic [MOD_W:0]  N_EXT = (MOD_W + 1)'(N_MOD);

    logic [MOD_W-1:0] acc_q;
    logic [MOD_W-1:0] a_q;
    logic [MOD_W-1:0] b_q;
    logic [CNT_W-1:0] cnt;
    logic             running;

    // One reduction step: acc = 2*acc mod N, then optionally acc = acc + a mod N.
    function automatic logic [MOD_W-1:0] mm_step(input logic [MOD_W-1:0] acc,
                                                 input logic [MOD_W-1:0] av,
                                                 input logic             bbit);
        logic [MOD_W:0] t;
        t = {acc, 1'b0};
        if (t >= N_EXT) t = t - N_EXT;
        if (bbit) begin
            t = t + {1'b0, av};
            if (t >= N_EXT) t = t - N_EXT;
        end
        return t[MOD_W-1:0];
    endfunction

    // Operand capture, step sequencing and done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc_q <= mm_step(MOD_W'(0), a, b[MOD_W-1]);
                a_q   <= a;
                b_q   <= b << 1;
                cnt   <= CNT_W'(1);
                if (MOD_W == 1) begin
                    done <= 1'b1;
                end else begin
                    running <= 1'b1;
                end
            end else if (running) begin
                acc_q <= mm_step(acc_q, a_q, b_q[MOD_W-1]);
                b_q   <= b_q << 1;
                cnt   <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(MOD_W - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign result = acc_q;

endmodule

// File: rtl/decrypt_responder.sv
// Far-end RSA responder: captures a ciphertext word, decrypts it with the fixed private
// key by LSB-first square-and-multiply, and returns the plaintext through the transmit port.
module decrypt_responder
    import rsa_link_pkg::*;
#(
    parameter int unsigned MOD_W = DEF_MOD_W,
    parameter int unsigned EXP_W = DEF_EXP_W,
    parameter int unsigned N_MOD = DEF_N_MOD,
    parameter int unsigned D_KEY = DEF_D_KEY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_received,
    input  logic [DATA_W-1:0] rx_data,
    output logic              tx_wr,
    output logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              error,
    output logic              overrun
);

    localparam int unsigned CNT_W = $clog2(EXP_W + 1);

    state_t            state;
    logic              rx_q;
    logic [DATA_W-1:0] c_q;
    logic [MOD_W-1:0]  res;
    logic [MOD_W-1:0]  base;
    logic [EXP_W-1:0]  exp_q;
    logic [CNT_W-1:0]  bit_cnt;

    logic              rx_edge_c;
    logic              out_of_range_c;
    logic              start_c;
    logic [MOD_W-1:0]  prod_a;
    logic [MOD_W-1:0]  prod_b;
    logic              done_a;
    logic              done_b;
    logic [MOD_W-1:0]  res_next_c;

    // Edge detect, range check and the multiply-or-keep choice for the running result.
    always_comb begin
        rx_edge_c      = rx_received & ~rx_q;
        out_of_range_c = (c_q[DATA_W-1:MOD_W] != '0) || (c_q[MOD_W-1:0] >= MOD_W'(N_MOD));
        start_c        = (state == S_LOAD);
        res_next_c     = exp_q[0] ? prod_a : res;
    end

    // res * base
    mod_mul #(.MOD_W(MOD_W), .N_MOD(N_MOD)) u_mul_a (
        .clock  (clock),
        .reset  (reset),
        .start  (start_c),
        .a      (res),
        .b      (base),
        .result (prod_a),
        .done   (done_a)
    );

    // base * base
    mod_mul #(.MOD_W(MOD_W), .N_MOD(N_MOD)) u_mul_b (
        .clock  (clock),
        .reset  (reset),
        .start  (start_c),
        .a      (base),
        .b      (base),
        .result (prod_b),
        .done   (done_b)
    );

    // Control FSM with registered reply, status and overrun outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            rx_q    <= 1'b0;
            c_q     <= '0;
            res     <= '0;
            base    <= '0;
            exp_q   <= '0;
            bit_cnt <= '0;
            tx_wr   <= 1'b0;
            tx_data <= '0;
            busy    <= 1'b0;
            error   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            rx_q  <= rx_received;
            tx_wr <= 1'b0;
            if (rx_edge_c && (state != S_IDLE)) overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (rx_edge_c) begin
                        c_q   <= rx_data;
                        busy  <= 1'b1;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (out_of_range_c) begin
                        tx_data <= ERR_WORD;
                        error   <= 1'b1;
                        tx_wr   <= 1'b1;
                        state   <= S_SEND;
                    end else begin
                        res     <= MOD_W'(1);
                        base    <= c_q[MOD_W-1:0];
                        exp_q   <= EXP_W'(D_KEY);
                        bit_cnt <= '0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= S_MUL;
                end
                S_MUL: begin
                    if (done_a && done_b) state <= S_STEP;
                end
                S_STEP: begin
                    res     <= res_next_c;
                    base    <= prod_b;
                    exp_q   <= exp_q >> 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(EXP_W - 1)) begin
                        tx_data <= {{(DATA_W - MOD_W){1'b0}}, res_next_c};
                        error   <= 1'b0;
                        tx_wr   <= 1'b1;
                        state   <= S_SEND;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                S_SEND: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/decrypt_responder.md
# decrypt_responder

Far-end responder for the inter-board ciphertext link. Waits for the link transceiver to signal a received 128-bit ciphertext word and decrypts it with the fixed RSA private key, using a sequential square-and-multiply modular exponentiation. It then writes the 128-bit plaintext back through the transceiver's transmit port. It sits between the link transceiver's receive and transmit sides on the decoding board.

## Interface
- `MOD_W`, default 16: arithmetic width of the modulus and residues.
- `EXP_W`, default 16: exponent bits processed; every bit is processed, with no early exit.
- `N_MOD`, default 2773: RSA modulus n.
- `D_KEY`, default 157: private exponent d.
- `clock`  in  1: system clock. All state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `rx_received`  in  1: level from the transceiver; a new word is valid on its rising edge.
- `rx_data`  in  128: ciphertext word from the transceiver; stable while `rx_received` is high.
- `tx_wr`  out  1: one-cycle write strobe to the transceiver. Reset value 0.
- `tx_data`  out  128: plaintext reply word, held until the next reply. Reset value 0.
- `busy`  out  1: high from capture until `tx_wr`, inclusive. Reset value 0.
- `error`  out  1: high with `tx_wr` when the captured ciphertext was out of range, else 0. Reset value 0.
- `overrun`  out  1: sticky flag. Set when a rising edge arrives while busy; cleared only by reset. Reset value 0.

## Operation
- Edge detect:
  - `rx_q` registers `rx_received`.
  - `rx_edge = rx_received & ~rx_q`.
  - `rx_q` resets to 0, so a level already high at reset release counts as an edge.
- States: IDLE, CHECK, LOAD, MUL, STEP, SEND.
- IDLE:
  - On `rx_edge`, capture `c = rx_data` into a 128-bit register.
  - Go to CHECK.
- CHECK:
  - If `c[127:MOD_W] != 0` or `c[MOD_W-1:0] >= N_MOD`, the input is out of range: load `tx_data = all ones`, set `error`, go to SEND.
  - Otherwise initialise: `res = 1`, `base = c[MOD_W-1:0]`, `exp = D_KEY`, `bit_cnt = 0`. Go to LOAD.
- LOAD:
  - Start both `mod_mul` instances in the same cycle: A computes `res*base`, B computes `base*base`.
  - Go to MUL.
- MUL:
  - Wait MOD_W cycles until both instances assert done (always simultaneously).
  - Go to STEP.
- STEP:
  - If `exp[0]`, `res <= A.result`; otherwise `res` is unchanged.
  - `base <= B.result`.
  - `exp <= exp >> 1`.
  - `bit_cnt <= bit_cnt + 1`.
  - If `bit_cnt == EXP_W-1`: load `tx_data = {zeros, res_next}`, clear `error`, go to SEND. Otherwise go to LOAD.
- SEND:
  - `tx_wr = 1` for exactly this one cycle.
  - Next state is IDLE; `busy` drops the following cycle.
- `mod_mul` (interleaved shift-add, operands < N_MOD):
  - Scans b MSB-first over MOD_W steps, with accumulator width MOD_W+1.
  - Each step: `acc = 2*acc`, subtract N if `>= N`; then if the b bit is set, `acc += a`, subtract N if `>= N`.
  - Result < N_MOD at all times. No `%` or `/` operator is used.
- Edges outside IDLE are ignored (no capture) and set `overrun`.
- Reset mid-operation:
  - Returns to IDLE, clears all outputs, and no `tx_wr` is issued.
  - A level still high after reset counts as a fresh edge.

## Timing
- Edge sampled at edge E0. Capture happens at E0 and CHECK occupies the next cycle.
- Valid data: `tx_wr` is high in the cycle beginning at edge E0 + 2 + EXP_W*(MOD_W+2). With defaults that is E0+290.
- Out-of-range data: `tx_wr` at E0+2.
- `tx_data` and `error` change only at the edge entering SEND, and hold afterwards.
- Back-to-back operation: a new edge is accepted one cycle after SEND, i.e. in IDLE.

## Structure
- Shared package `rsa_link_pkg` holds:
  - the state enum;
  - default `N_MOD`, `D_KEY`, `MOD_W`, `EXP_W`;
  - the `ERR_WORD` all-ones constant.
- Sub-module `mod_mul`:
  - Ports: clock, reset, start, a, b, result, done; parameters MOD_W, N_MOD.
  - Instantiated twice.

## Test plan
- Decrypt a nominal word: `rx_data=332` with a rising edge → single `tx_wr` at E0+290, `tx_data=65`, `error=0`. This matches m=65, e=17, n=2773.
- Trivial inputs: `rx_data=0` → `tx_data=0`; `rx_data=1` → `tx_data=1`. Both at E0+290, with `busy` high for the whole window.
- Out of range: `rx_data=2773`, and separately `rx_data=1<<64` → `tx_wr` at E0+2, `tx_data` all ones, `error=1`.
- Overrun: second rising edge at E0+50 with `rx_data=5` → exactly one `tx_wr` with `tx_data=65`, and `overrun=1` sticky until reset.
- Reset mid-operation: assert `reset` at E0+100 → `tx_wr` never pulses, all outputs 0. A new 332 edge after reset yields 65.
- Held level: `rx_received` held high for 1000 cycles → exactly one reply.
